// File: rtl/ring_nic_pkg.sv
// rtl/ring_nic_pkg.sv - shared constants, packet layout and status helper for the ring NIC
// Purpose: register addresses, packet field positions, status bit positions and the
//          status-word packing function used by ring_nic.
// Ports:   none (package)
package ring_nic_pkg;

    localparam logic [2:0] ADDR_EJ_DATA   = 3'd0;
    localparam logic [2:0] ADDR_EJ_STAT   = 3'd1;
    localparam logic [2:0] ADDR_INJ_DATA  = 3'd2;
    localparam logic [2:0] ADDR_INJ_STAT  = 3'd3;
    localparam logic [2:0] ADDR_TX_CNT    = 3'd4;
    localparam logic [2:0] ADDR_RX_CNT    = 3'd5;
    localparam logic [2:0] ADDR_STALL_CNT = 3'd6;
    localparam logic [2:0] ADDR_CTRL      = 3'd7;

    localparam int PKT_VC      = 63;
    localparam int PKT_DIR     = 62;
    localparam int PKT_HOP_HI  = 55;
    localparam int PKT_HOP_LO  = 48;
    localparam int PKT_SRC_HI  = 47;
    localparam int PKT_SRC_LO  = 32;
    localparam int PKT_DATA_HI = 31;
    localparam int PKT_DATA_LO = 0;

    localparam int STAT_CNT_LSB   = 8;
    localparam int EJ_STAT_FULL   = 1;
    localparam int EJ_STAT_NEMPTY = 0;
    localparam int INJ_STAT_EMPTY = 1;
    localparam int INJ_STAT_FULL  = 0;

    typedef struct packed {
        logic        vc;
        logic        dir;
        logic [5:0]  rsvd;
        logic [7:0]  hop;
        logic [15:0] src;
        logic [31:0] data;
    } pkt_t;

    // Occupancy sits at bit 8 upward, two flag bits at [1:0]; everything else reads 0.
    function automatic logic [63:0] status_word(input logic [7:0] cnt,
                                                input logic       b1,
                                                input logic       b0);
        logic [63:0] w;
        w = '0;
        w[STAT_CNT_LSB +: 8] = cnt;
        w[1] = b1;
        w[0] = b0;
        return w;
    endfunction

endpackage

// File: rtl/ring_nic_fifo.sv
// rtl/ring_nic_fifo.sv - synchronous FIFO used for the inject and eject queues
// Purpose: DEPTH-entry first-word-fall-through queue; head is the oldest entry.
// Ports:   clk, reset (sync, active-high); push/push_data write (dropped when full);
//          pop (ignored when empty); head, full, empty, count ($clog2(DEPTH)+1 bits).
module ring_nic_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full is the pre-edge state: a push into a full queue is lost even if a pop
    // drains an entry on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ring_nic.sv
// rtl/ring_nic.sv - processor/ring network interface with inject and eject queues
// Purpose: register map for the processor, inject queue gated by ring polarity,
//          eject queue fed by the router, and tx/rx/stall debug counters.
// Ports:   clk, reset (sync, active-high); addr/d_in/d_out/nicEn/nicEnWr processor side;
//          net_si/net_ri/net_di eject handshake; net_so/net_ro/net_do inject handshake;
//          net_polarity ring phase.
module ring_nic
    import ring_nic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicEnWr,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rd_en;
    logic          wr_en;

    logic [63:0]   ej_head;
    logic          ej_full;
    logic          ej_empty;
    logic [CW-1:0] ej_count;
    logic          ej_push;
    logic          ej_pop;

    logic [63:0]   inj_head;
    logic          inj_full;
    logic          inj_empty;
    logic [CW-1:0] inj_count;
    logic          inj_push;
    pkt_t          inj_pkt;

    logic          cnt_clear;
    logic [CNTW-1:0] tx_cnt;
    logic [CNTW-1:0] rx_cnt;
    logic [CNTW-1:0] stall_cnt;

    assign rd_en = nicEn && !nicEnWr;
    assign wr_en = nicEn && nicEnWr;

    assign net_ri  = !reset && !ej_full;
    // A packet offered while net_ri is low is simply not pushed.
    assign ej_push = net_si && net_ri;
    assign ej_pop  = rd_en && (addr == ADDR_EJ_DATA) && !ej_empty;

    assign inj_push = wr_en && (addr == ADDR_INJ_DATA);
    assign inj_pkt  = pkt_t'(inj_head);
    // Injection only on the packet's own virtual-channel phase of the ring.
    assign net_so   = !reset && !inj_empty && net_ro && (inj_pkt.vc == net_polarity);
    assign net_do   = inj_head;

    assign cnt_clear = wr_en && (addr == ADDR_CTRL);

    ring_nic_fifo #(.DEPTH(DEPTH), .W(64)) u_ej_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ej_push),
        .push_data (net_di),
        .pop       (ej_pop),
        .head      (ej_head),
        .full      (ej_full),
        .empty     (ej_empty),
        .count     (ej_count)
    );

    ring_nic_fifo #(.DEPTH(DEPTH), .W(64)) u_inj_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inj_push),
        .push_data (d_in),
        .pop       (net_so),
        .head      (inj_head),
        .full      (inj_full),
        .empty     (inj_empty),
        .count     (inj_count)
    );

    // Clear has priority over any increment occurring on the same edge.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (net_so) begin
                tx_cnt <= tx_cnt + CNTW'(1);
            end
            if (ej_push) begin
                rx_cnt <= rx_cnt + CNTW'(1);
            end
            if (!inj_empty && !net_so) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_EJ_DATA:   d_out = ej_empty ? 64'd0 : ej_head;
                ADDR_EJ_STAT:   d_out = status_word(8'(ej_count), ej_full, !ej_empty);
                ADDR_INJ_STAT:  d_out = status_word(8'(inj_count), inj_empty, inj_full);
                ADDR_TX_CNT:    d_out = 64'(tx_cnt);
                ADDR_RX_CNT:    d_out = 64'(rx_cnt);
                ADDR_STALL_CNT: d_out = 64'(stall_cnt);
                default:        d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// tb/tb_ring_nic.sv - directed self-checking bench for ring_nic
module tb_ring_nic;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  addr = '0;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicEnWr = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    ring_nic #(.DEPTH(4), .CNTW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 net_polarity = ~net_polarity;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic reg_write(input logic [2:0] a, input logic [63:0] d);
        @(negedge clk);
        addr = a; d_in = d; nicEn = 1'b1; nicEnWr = 1'b1;
        @(posedge clk);
        #1 nicEn = 1'b0; nicEnWr = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [63:0] d);
        @(negedge clk);
        addr = a; nicEn = 1'b1; nicEnWr = 1'b0;
        #1 d = d_out;
        @(posedge clk);
        #1 nicEn = 1'b0;
    endtask

    task automatic test_reset;
        logic [63:0] v;
        reset = 1'b1; net_ro = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (net_ri !== 1'b0) begin n_bad++; $display("FAIL reset_ri got %0b need 0", net_ri); end
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL reset_so got %0b need 0", net_so); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL post_reset_ri got %0b need 1", net_ri); end
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL post_reset_so got %0b need 0", net_so); end
        n_cmp++; if (d_out !== 64'd0) begin n_bad++; $display("FAIL post_reset_dout got %h need 0", d_out); end
        reg_read(3'd3, v);
        n_cmp++; if (v !== 64'h2) begin n_bad++; $display("FAIL reset_inj_stat got %h need 2", v); end
        reg_read(3'd1, v);
        n_cmp++; if (v !== 64'h0) begin n_bad++; $display("FAIL reset_ej_stat got %h need 0", v); end
        for (int a = 4; a <= 6; a++) begin
            reg_read(3'(a), v);
            n_cmp++; if (v !== 64'h0) begin n_bad++; $display("FAIL reset_cnt%0d got %h need 0", a, v); end
        end
    endtask

    task automatic test_polarity_inject;
        logic [63:0] v;
        logic sent, exp_so;
        sent = 1'b0;
        net_ro = 1'b1;
        reg_write(3'd2, 64'h8000_0000_0000_00AA);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            exp_so = net_polarity && !sent;
            n_cmp++; if (net_so !== exp_so) begin n_bad++; $display("FAIL inj_so_c%0d got %0b need %0b", i, net_so, exp_so); end
            if (exp_so) begin
                n_cmp++; if (net_do !== 64'h8000_0000_0000_00AA) begin n_bad++; $display("FAIL inj_do got %h need 80000000000000aa", net_do); end
                sent = 1'b1;
            end
        end
        reg_read(3'd4, v);
        n_cmp++; if (v !== 64'd1) begin n_bad++; $display("FAIL inj_tx got %h need 1", v); end
        reg_read(3'd3, v);
        n_cmp++; if (v !== 64'h2) begin n_bad++; $display("FAIL inj_stat_empty got %h need 2", v); end
    endtask

    task automatic test_eject;
        logic [63:0] v;
        net_ro = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            net_si = 1'b1; net_di = 64'h11 + 64'(i);
            #1;
            n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL ej_ri_push%0d got %0b need 1", i, net_ri); end
        end
        @(negedge clk);
        net_di = 64'h99;          // offered while full: must be dropped
        #1;
        n_cmp++; if (net_ri !== 1'b0) begin n_bad++; $display("FAIL ej_ri_full got %0b need 0", net_ri); end
        @(negedge clk);
        net_si = 1'b0;
        reg_read(3'd1, v);
        n_cmp++; if (v !== 64'h403) begin n_bad++; $display("FAIL ej_stat_full got %h need 403", v); end
        reg_read(3'd5, v);
        n_cmp++; if (v !== 64'd4) begin n_bad++; $display("FAIL ej_rx got %h need 4", v); end
        reg_read(3'd0, v);
        n_cmp++; if (v !== 64'h11) begin n_bad++; $display("FAIL ej_pop0 got %h need 11", v); end
        @(negedge clk);
        #1;
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL ej_ri_after_pop got %0b need 1", net_ri); end
        // processor pop and router push on the same edge
        @(negedge clk);
        addr = 3'd0; nicEn = 1'b1; nicEnWr = 1'b0; net_si = 1'b1; net_di = 64'h15;
        #1 v = d_out;
        @(posedge clk);
        #1 nicEn = 1'b0; net_si = 1'b0;
        n_cmp++; if (v !== 64'h12) begin n_bad++; $display("FAIL ej_pop_push got %h need 12", v); end
        reg_read(3'd1, v);
        n_cmp++; if (v !== 64'h301) begin n_bad++; $display("FAIL ej_stat_3 got %h need 301", v); end
        for (int i = 0; i < 3; i++) begin
            reg_read(3'd0, v);
            n_cmp++; if (v !== 64'h13 + 64'(i)) begin n_bad++; $display("FAIL ej_drain%0d got %h need %h", i, v, 64'h13 + 64'(i)); end
        end
        reg_read(3'd0, v);
        n_cmp++; if (v !== 64'h0) begin n_bad++; $display("FAIL ej_empty_read got %h need 0", v); end
    endtask

    task automatic test_stall;
        logic [63:0] v;
        logic sent, exp_so;
        int stall_exp;
        reg_write(3'd7, 64'h0);
        net_ro = 1'b0;
        reg_write(3'd2, 64'h8000_0000_0000_0001);
        stall_exp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL stall_so_c%0d got %0b need 0", i, net_so); end
            stall_exp++;
        end
        sent = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            net_ro = 1'b1;
            #1;
            exp_so = net_polarity && !sent;
            n_cmp++; if (net_so !== exp_so) begin n_bad++; $display("FAIL stall_inj_c%0d got %0b need %0b", i, net_so, exp_so); end
            if (exp_so) sent = 1'b1;
            else if (!sent) stall_exp++;
        end
        reg_read(3'd6, v);
        n_cmp++; if (v !== 64'(stall_exp)) begin n_bad++; $display("FAIL stall_cnt got %0d need %0d", v, stall_exp); end
        reg_read(3'd6, v);
        n_cmp++; if (v !== 64'(stall_exp)) begin n_bad++; $display("FAIL stall_cnt_frozen got %0d need %0d", v, stall_exp); end
        reg_read(3'd4, v);
        n_cmp++; if (v !== 64'd1) begin n_bad++; $display("FAIL stall_tx got %0d need 1", v); end
        reg_write(3'd7, 64'h0);
        for (int a = 4; a <= 6; a++) begin
            reg_read(3'(a), v);
            n_cmp++; if (v !== 64'h0) begin n_bad++; $display("FAIL clear_cnt%0d got %h need 0", a, v); end
        end
    endtask

    task automatic test_inject_full;
        logic [63:0] v;
        logic exp_so;
        int next;
        net_ro = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            reg_write(3'd2, 64'(i));
        end
        reg_read(3'd3, v);
        n_cmp++; if (v !== 64'h401) begin n_bad++; $display("FAIL inj_stat_full got %h need 401", v); end
        next = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            net_ro = 1'b1;
            #1;
            exp_so = !net_polarity && (next <= 4);
            n_cmp++; if (net_so !== exp_so) begin n_bad++; $display("FAIL full_drain_so_c%0d got %0b need %0b", i, net_so, exp_so); end
            if (exp_so) begin
                n_cmp++; if (net_do !== 64'(next)) begin n_bad++; $display("FAIL full_drain_do got %h need %h", net_do, 64'(next)); end
                next++;
            end
        end
        reg_read(3'd3, v);
        n_cmp++; if (v !== 64'h2) begin n_bad++; $display("FAIL inj_stat_drained got %h need 2", v); end
        reg_read(3'd4, v);
        n_cmp++; if (v !== 64'd4) begin n_bad++; $display("FAIL full_tx got %0d need 4", v); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] v;
        net_ro = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            net_si = 1'b1; net_di = 64'h40 + 64'(i);
        end
        @(negedge clk);
        net_si = 1'b0;
        reg_write(3'd2, 64'h8000_0000_0000_0050);
        reg_write(3'd2, 64'h0000_0000_0000_0051);
        reg_write(3'd2, 64'h8000_0000_0000_0052);
        @(negedge clk);
        reset = 1'b1; net_ro = 1'b1;
        #1;
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL rst_mid_so got %0b need 0", net_so); end
        n_cmp++; if (net_ri !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ri got %0b need 0", net_ri); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL rst_after_so_c%0d got %0b need 0", i, net_so); end
        end
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL rst_after_ri got %0b need 1", net_ri); end
        reg_read(3'd3, v);
        n_cmp++; if (v !== 64'h2) begin n_bad++; $display("FAIL rst_inj_stat got %h need 2", v); end
        reg_read(3'd1, v);
        n_cmp++; if (v !== 64'h0) begin n_bad++; $display("FAIL rst_ej_stat got %h need 0", v); end
        for (int a = 4; a <= 6; a++) begin
            reg_read(3'(a), v);
            n_cmp++; if (v !== 64'h0) begin n_bad++; $display("FAIL rst_cnt%0d got %h need 0", a, v); end
        end
    endtask

    initial begin
        test_reset;
        test_polarity_inject;
        test_eject;
        test_stall;
        test_inject_full;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
